// File: rtl/usart_pkg.sv
// Shared register offsets, bit positions and RX entry layout for the USART register block.
package usart_pkg;

    localparam logic [7:0] OFF_UDR   = 8'd0;
    localparam logic [7:0] OFF_UCSRA = 8'd1;
    localparam logic [7:0] OFF_UCSRB = 8'd2;
    localparam logic [7:0] OFF_UCSRC = 8'd3;
    localparam logic [7:0] OFF_UBRRL = 8'd4;
    localparam logic [7:0] OFF_FSTAT = 8'd5;

    localparam int UCSRA_RXC  = 7;
    localparam int UCSRA_TXC  = 6;
    localparam int UCSRA_UDRE = 5;
    localparam int UCSRA_FE   = 4;
    localparam int UCSRA_DOR  = 3;
    localparam int UCSRA_PE   = 2;
    localparam int UCSRA_U2X  = 1;
    localparam int UCSRA_MPCM = 0;

    localparam int UCSRB_RXCIE = 7;
    localparam int UCSRB_TXCIE = 6;
    localparam int UCSRB_UDRIE = 5;
    localparam int UCSRB_RXEN  = 4;
    localparam int UCSRB_TXEN  = 3;
    localparam int UCSRB_UCSZ2 = 2;
    localparam int UCSRB_RXB8  = 1;
    localparam int UCSRB_TX8   = 0;

    localparam int UCSRC_URSEL = 7;
    localparam int UCSRC_UMSEL = 6;
    localparam int UCSRC_UPM1  = 5;
    localparam int UCSRC_UPM0  = 4;
    localparam int UCSRC_USBS  = 3;
    localparam int UCSRC_UCSZ1 = 2;
    localparam int UCSRC_UCSZ0 = 1;
    localparam int UCSRC_UCPOL = 0;

    localparam int RXE_W   = 11;
    localparam int RXE_FE  = 10;
    localparam int RXE_PE  = 9;
    localparam int RXE_RX8 = 8;

    function automatic logic [3:0] sat_nibble(input logic [15:0] v);
        return (v > 16'd15) ? 4'hF : v[3:0];
    endfunction

endpackage

// File: rtl/usart_fifo.sv
// Synchronous FIFO with flush and occupancy level; a push into a full FIFO is accepted when a pop frees a slot.
module usart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [LW-1:0]    count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign empty     = (count_r == LW'(0));
    assign full      = (count_r == LW'(DEPTH));
    assign level     = count_r;
    assign dout      = mem_r[rd_ptr_r];
    assign pop_ok_s  = pop & ~empty;
    assign push_ok_s = push & (~full | pop_ok_s);

    // Storage, pointers and occupancy; flush wins over any same-cycle push or pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else if (flush) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= din;
                wr_ptr_r        <= wr_ptr_r + AW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            count_r <= count_r + LW'(push_ok_s) - LW'(pop_ok_s);
        end
    end

endmodule

// File: rtl/usart_regs_fifo.sv
// AVR-style USART register file with TX/RX FIFOs, status flags, baud divisor and interrupt request.
module usart_regs_fifo
    import usart_pkg::*;
#(
    parameter logic [7:0] BASE_ADDR = 8'h00,
    parameter int         TX_DEPTH  = 4,
    parameter int         RX_DEPTH  = 4,
    parameter int         UBRR_W    = 12
) (
    input  logic              i_fosk,
    input  logic              i_rst_n,
    input  logic [7:0]        i_addr,
    input  logic [7:0]        i_word,
    input  logic              i_we,
    input  logic              i_re,
    output logic [7:0]        o_word,
    output logic [8:0]        o_tx_data,
    output logic              o_tx_valid,
    input  logic              i_tx_ready,
    input  logic              i_txc,
    input  logic [8:0]        i_rx_data,
    input  logic              i_rx_fe,
    input  logic              i_rx_pe,
    input  logic              i_rx_valid,
    output logic [UBRR_W-1:0] o_ubrr,
    output logic              o_ubrr_we,
    output logic              o_u2x,
    output logic              o_mpcm,
    output logic              o_txen,
    output logic              o_rxen,
    output logic              o_usbs,
    output logic              o_umsel,
    output logic              o_ucpol,
    output logic [2:0]        o_ucsz,
    output logic [1:0]        o_upm,
    output logic              o_irq
);
    localparam logic [7:0] ADR_UDR   = BASE_ADDR + OFF_UDR;
    localparam logic [7:0] ADR_UCSRA = BASE_ADDR + OFF_UCSRA;
    localparam logic [7:0] ADR_UCSRB = BASE_ADDR + OFF_UCSRB;
    localparam logic [7:0] ADR_UCSRC = BASE_ADDR + OFF_UCSRC;
    localparam logic [7:0] ADR_UBRRL = BASE_ADDR + OFF_UBRRL;
    localparam logic [7:0] ADR_FSTAT = BASE_ADDR + OFF_FSTAT;

    logic u2x_r, mpcm_r, txc_r, dor_r, txc_prev_r, toggle_r, ubrr_we_r;
    logic rxcie_r, txcie_r, udrie_r, rxen_r, txen_r, ucsz2_r, tx8_r;
    logic umsel_r, usbs_r, ucpol_r;
    logic [1:0] upm_r, ucsz_r;
    logic [UBRR_W-1:0] ubrr_r;

    logic sel_udr_s, sel_ucsra_s, sel_ucsrb_s, sel_ucsrc_s, sel_ubrrl_s;
    logic wr_udr_s, wr_ucsra_s, wr_ucsrb_s, wr_ucsrc_s, wr_ubrrl_s;
    logic tx_push_s, tx_pop_s, tx_flush_s, tx_full_s, tx_empty_s;
    logic rx_push_s, rx_pop_s, rx_flush_s, rx_full_s, rx_empty_s, rx_frame_s, rx_drop_s;
    logic txc_set_s, txc_clr_s, ubrr_wr_s;
    logic [8:0]              tx_head_s;
    logic [RXE_W-1:0]        rx_head_s;
    logic [RXE_W-1:0]        rx_vis_s;
    logic [$clog2(TX_DEPTH):0] tx_level_s;
    logic [$clog2(RX_DEPTH):0] rx_level_s;
    logic [7:0] ucsra_s, ucsrb_s, ucsrc_s, ubrrh_s, fstat_s;

    assign sel_udr_s   = (i_addr == ADR_UDR);
    assign sel_ucsra_s = (i_addr == ADR_UCSRA);
    assign sel_ucsrb_s = (i_addr == ADR_UCSRB);
    assign sel_ucsrc_s = (i_addr == ADR_UCSRC);
    assign sel_ubrrl_s = (i_addr == ADR_UBRRL);
    assign wr_udr_s    = i_we & sel_udr_s;
    assign wr_ucsra_s  = i_we & sel_ucsra_s;
    assign wr_ucsrb_s  = i_we & sel_ucsrb_s;
    assign wr_ucsrc_s  = i_we & sel_ucsrc_s;
    assign wr_ubrrl_s  = i_we & sel_ubrrl_s;

    assign o_tx_valid = ~tx_empty_s & txen_r;
    assign o_tx_data  = tx_head_s;
    assign tx_push_s  = wr_udr_s & txen_r & ~tx_full_s;
    assign tx_pop_s   = o_tx_valid & i_tx_ready;
    assign tx_flush_s = wr_ucsrb_s & ~i_word[UCSRB_TXEN];

    // An RX frame arriving at a full FIFO still lands if the CPU pops UDR in the same cycle.
    assign rx_pop_s   = i_re & sel_udr_s & ~rx_empty_s;
    assign rx_frame_s = i_rx_valid & rxen_r;
    assign rx_push_s  = rx_frame_s & (~rx_full_s | rx_pop_s);
    assign rx_drop_s  = rx_frame_s & ~rx_push_s;
    assign rx_flush_s = wr_ucsrb_s & ~i_word[UCSRB_RXEN];
    assign rx_vis_s   = rx_empty_s ? {RXE_W{1'b0}} : rx_head_s;

    assign txc_set_s = i_txc & ~txc_prev_r & tx_empty_s;
    assign txc_clr_s = wr_ucsra_s & i_word[UCSRA_TXC];
    assign ubrr_wr_s = (wr_ucsrc_s & ~i_word[UCSRC_URSEL]) | wr_ubrrl_s;

    usart_fifo #(.WIDTH(9), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk(i_fosk), .rst_n(i_rst_n), .flush(tx_flush_s), .push(tx_push_s), .pop(tx_pop_s),
        .din({tx8_r, i_word}), .dout(tx_head_s), .full(tx_full_s), .empty(tx_empty_s),
        .level(tx_level_s)
    );

    usart_fifo #(.WIDTH(RXE_W), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk(i_fosk), .rst_n(i_rst_n), .flush(rx_flush_s), .push(rx_push_s), .pop(rx_pop_s),
        .din({i_rx_fe, i_rx_pe, i_rx_data}), .dout(rx_head_s), .full(rx_full_s),
        .empty(rx_empty_s), .level(rx_level_s)
    );

    // Control/status registers, baud divisor and the +3 read toggle.
    always_ff @(posedge i_fosk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            {u2x_r, mpcm_r, txc_r, dor_r, txc_prev_r, toggle_r, ubrr_we_r} <= 7'b0;
            {rxcie_r, txcie_r, udrie_r, rxen_r, txen_r, ucsz2_r, tx8_r}   <= 7'b0;
            {umsel_r, usbs_r, ucpol_r} <= 3'b0;
            upm_r  <= 2'b0;
            ucsz_r <= 2'b0;
            ubrr_r <= '0;
        end else begin
            txc_prev_r <= i_txc;
            ubrr_we_r  <= ubrr_wr_s;
            if (wr_ucsra_s) begin
                u2x_r  <= i_word[UCSRA_U2X];
                mpcm_r <= i_word[UCSRA_MPCM];
            end
            if (txc_set_s) begin
                txc_r <= 1'b1;
            end else if (txc_clr_s) begin
                txc_r <= 1'b0;
            end
            if (rx_flush_s) begin
                dor_r <= 1'b0;
            end else if (rx_drop_s) begin
                dor_r <= 1'b1;
            end else if (rx_pop_s) begin
                dor_r <= 1'b0;
            end
            if (wr_ucsrb_s) begin
                {rxcie_r, txcie_r, udrie_r, rxen_r, txen_r, ucsz2_r} <= i_word[7:2];
                tx8_r <= i_word[UCSRB_TX8];
            end
            if (wr_ucsrc_s && i_word[UCSRC_URSEL]) begin
                umsel_r <= i_word[UCSRC_UMSEL];
                upm_r   <= i_word[UCSRC_UPM1:UCSRC_UPM0];
                usbs_r  <= i_word[UCSRC_USBS];
                ucsz_r  <= i_word[UCSRC_UCSZ1:UCSRC_UCSZ0];
                ucpol_r <= i_word[UCSRC_UCPOL];
            end else if (wr_ucsrc_s) begin
                ubrr_r <= {i_word[UBRR_W-9:0], ubrr_r[7:0]};
            end else if (wr_ubrrl_s) begin
                ubrr_r <= {ubrr_r[UBRR_W-1:8], i_word};
            end
            if (i_re && sel_ucsrc_s) begin
                toggle_r <= ~toggle_r;
            end else if ((i_re || i_we) && !sel_ucsrc_s) begin
                toggle_r <= 1'b0;
            end
        end
    end

    assign ucsra_s = {~rx_empty_s, txc_r, ~tx_full_s, rx_vis_s[RXE_FE], dor_r,
                      rx_vis_s[RXE_PE], u2x_r, mpcm_r};
    assign ucsrb_s = {rxcie_r, txcie_r, udrie_r, rxen_r, txen_r, ucsz2_r,
                      rx_vis_s[RXE_RX8], tx8_r};
    assign ucsrc_s = {1'b1, umsel_r, upm_r, usbs_r, ucsz_r, ucpol_r};
    assign ubrrh_s = 8'(ubrr_r >> 8);
    assign fstat_s = {sat_nibble(16'(tx_level_s)), sat_nibble(16'(rx_level_s))};

    // Read data mux; unmapped addresses read as zero.
    always_comb begin
        o_word = 8'h00;
        case (i_addr)
            ADR_UDR:   o_word = rx_vis_s[7:0];
            ADR_UCSRA: o_word = ucsra_s;
            ADR_UCSRB: o_word = ucsrb_s;
            ADR_UCSRC: o_word = toggle_r ? ucsrc_s : ubrrh_s;
            ADR_UBRRL: o_word = ubrr_r[7:0];
            ADR_FSTAT: o_word = fstat_s;
            default:   o_word = 8'h00;
        endcase
    end

    assign o_ubrr    = ubrr_r;
    assign o_ubrr_we = ubrr_we_r;
    assign o_u2x     = u2x_r;
    assign o_mpcm    = mpcm_r;
    assign o_txen    = txen_r;
    assign o_rxen    = rxen_r;
    assign o_usbs    = usbs_r;
    assign o_umsel   = umsel_r;
    assign o_ucpol   = ucpol_r;
    assign o_ucsz    = {ucsz2_r, ucsz_r};
    assign o_upm     = upm_r;
    assign o_irq     = (rxcie_r & ~rx_empty_s) | (txcie_r & txc_r) | (udrie_r & ~tx_full_s);

endmodule

// File: tb/tb_usart_regs_fifo.sv
// Directed-vector bench for usart_regs_fifo at a non-zero base address.
module tb_usart_regs_fifo;
    localparam logic [7:0] BASE = 8'h40;

    logic        i_fosk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic [7:0]  i_addr = 8'h00;
    logic [7:0]  i_word = 8'h00;
    logic        i_we = 1'b0;
    logic        i_re = 1'b0;
    logic [7:0]  o_word;
    logic [8:0]  o_tx_data;
    logic        o_tx_valid;
    logic        i_tx_ready = 1'b0;
    logic        i_txc = 1'b0;
    logic [8:0]  i_rx_data = 9'h000;
    logic        i_rx_fe = 1'b0;
    logic        i_rx_pe = 1'b0;
    logic        i_rx_valid = 1'b0;
    logic [11:0] o_ubrr;
    logic        o_ubrr_we;
    logic        o_u2x, o_mpcm, o_txen, o_rxen, o_usbs, o_umsel, o_ucpol;
    logic [2:0]  o_ucsz;
    logic [1:0]  o_upm;
    logic        o_irq;

    int n_vec = 0;
    int n_err = 0;

    usart_regs_fifo #(.BASE_ADDR(BASE), .TX_DEPTH(4), .RX_DEPTH(4), .UBRR_W(12)) dut (
        .i_fosk(i_fosk), .i_rst_n(i_rst_n), .i_addr(i_addr), .i_word(i_word),
        .i_we(i_we), .i_re(i_re), .o_word(o_word), .o_tx_data(o_tx_data),
        .o_tx_valid(o_tx_valid), .i_tx_ready(i_tx_ready), .i_txc(i_txc),
        .i_rx_data(i_rx_data), .i_rx_fe(i_rx_fe), .i_rx_pe(i_rx_pe),
        .i_rx_valid(i_rx_valid), .o_ubrr(o_ubrr), .o_ubrr_we(o_ubrr_we),
        .o_u2x(o_u2x), .o_mpcm(o_mpcm), .o_txen(o_txen), .o_rxen(o_rxen),
        .o_usbs(o_usbs), .o_umsel(o_umsel), .o_ucpol(o_ucpol), .o_ucsz(o_ucsz),
        .o_upm(o_upm), .o_irq(o_irq)
    );

    always #5 i_fosk = ~i_fosk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_fosk);
        #1;
    endtask

    task automatic wr(input logic [7:0] off, input logic [7:0] d);
        i_addr = BASE + off;
        i_word = d;
        i_we   = 1'b1;
        tick();
        i_we   = 1'b0;
    endtask

    task automatic rd(input logic [7:0] off, input logic [7:0] exp, input string tag);
        i_addr = BASE + off;
        i_re   = 1'b1;
        #1;
        chk(tag, 16'(o_word), 16'(exp));
        tick();
        i_re   = 1'b0;
    endtask

    task automatic peek(input logic [7:0] off, input logic [7:0] exp, input string tag);
        i_addr = BASE + off;
        #1;
        chk(tag, 16'(o_word), 16'(exp));
    endtask

    task automatic rx_frame(input logic fe, input logic pe, input logic [8:0] d);
        i_rx_fe    = fe;
        i_rx_pe    = pe;
        i_rx_data  = d;
        i_rx_valid = 1'b1;
        tick();
        i_rx_valid = 1'b0;
    endtask

    initial begin
        // reset state
        tick(); tick();
        i_rst_n = 1'b1;
        tick();
        peek(8'd1, 8'h20, "rst_ucsra");
        peek(8'd2, 8'h00, "rst_ucsrb");
        peek(8'd5, 8'h00, "rst_fstat");
        chk("rst_txvalid", 16'(o_tx_valid), 16'h0);
        chk("rst_ubrr", 16'(o_ubrr), 16'h000);
        chk("rst_irq", 16'(o_irq), 16'h0);
        peek(8'd6, 8'h00, "unmapped");

        // TX fill with one write dropped on full
        wr(8'd2, 8'h08);
        chk("txen", 16'(o_txen), 16'h1);
        for (int i = 0; i < 5; i++) wr(8'd0, 8'h11 + 8'(i));
        peek(8'd5, 8'h40, "tx_full_fstat");
        peek(8'd1, 8'h00, "tx_full_ucsra");
        chk("tx_valid", 16'(o_tx_valid), 16'h1);
        chk("tx_head0", 16'(o_tx_data), 16'h011);
        i_tx_ready = 1'b1;
        tick();
        i_tx_ready = 1'b0;
        chk("tx_head1", 16'(o_tx_data), 16'h012);
        peek(8'd5, 8'h30, "tx_pop_fstat");
        wr(8'd2, 8'h09);
        wr(8'd0, 8'hAB);
        peek(8'd5, 8'h40, "tx8_fstat");
        i_tx_ready = 1'b1;
        tick(); tick(); tick();
        i_tx_ready = 1'b0;
        chk("tx8_head", 16'(o_tx_data), 16'h1AB);
        wr(8'd2, 8'h00);
        chk("flush_valid", 16'(o_tx_valid), 16'h0);
        peek(8'd5, 8'h00, "flush_fstat");

        // TXC set, interrupt, set-beats-clear
        wr(8'd2, 8'h48);
        i_txc = 1'b1;
        tick();
        peek(8'd1, 8'h60, "txc_set");
        chk("txc_irq", 16'(o_irq), 16'h1);
        i_txc = 1'b0;
        tick();
        i_txc = 1'b1;
        wr(8'd1, 8'h40);
        peek(8'd1, 8'h60, "txc_set_wins");
        wr(8'd1, 8'h42);
        peek(8'd1, 8'h22, "txc_clear");
        chk("u2x", 16'(o_u2x), 16'h1);
        chk("irq_off", 16'(o_irq), 16'h0);
        i_txc = 1'b0;

        // RX fill, overrun with and without concurrent pop
        wr(8'd2, 8'h10);
        rx_frame(1'b1, 1'b0, 9'h1A1);
        rx_frame(1'b0, 1'b0, 9'h0B2);
        rx_frame(1'b0, 1'b1, 9'h0C3);
        rx_frame(1'b0, 1'b0, 9'h0D4);
        peek(8'd5, 8'h04, "rx_full_fstat");
        peek(8'd1, 8'hB2, "rx_full_ucsra");
        peek(8'd2, 8'h12, "rx_rxb8");
        i_rx_data = 9'h0E5; i_rx_fe = 1'b0; i_rx_pe = 1'b0; i_rx_valid = 1'b1;
        rd(8'd0, 8'hA1, "rx_pop_push");
        i_rx_valid = 1'b0;
        peek(8'd5, 8'h04, "rx_pp_fstat");
        peek(8'd1, 8'hA2, "rx_pp_nodor");
        rx_frame(1'b0, 1'b0, 9'h0F6);
        peek(8'd1, 8'hAA, "rx_dor_set");
        rd(8'd0, 8'hB2, "rx_rd_b2");
        peek(8'd1, 8'hA6, "rx_dor_clr_pe");
        peek(8'd5, 8'h03, "rx_fstat3");
        rd(8'd0, 8'hC3, "rx_rd_c3");
        rd(8'd0, 8'hD4, "rx_rd_d4");
        rd(8'd0, 8'hE5, "rx_rd_e5");
        rd(8'd0, 8'h00, "rx_rd_empty");
        peek(8'd1, 8'h22, "rx_empty_ucsra");

        // baud divisor and +3 read toggle
        wr(8'd3, 8'h05);
        chk("ubrrh_val", 16'(o_ubrr), 16'h500);
        chk("ubrrh_we", 16'(o_ubrr_we), 16'h1);
        tick();
        chk("ubrr_we_pulse", 16'(o_ubrr_we), 16'h0);
        wr(8'd4, 8'hA0);
        chk("ubrrl_val", 16'(o_ubrr), 16'h5A0);
        chk("ubrrl_we", 16'(o_ubrr_we), 16'h1);
        wr(8'd3, 8'h86);
        chk("ucsrc_no_we", 16'(o_ubrr_we), 16'h0);
        chk("ucsrc_ubrr", 16'(o_ubrr), 16'h5A0);
        chk("ucsz", 16'(o_ucsz), 16'h3);
        wr(8'd7, 8'hFF);
        rd(8'd3, 8'h05, "rd3_ubrrh");
        rd(8'd3, 8'h86, "rd3_ucsrc");
        peek(8'd4, 8'hA0, "ubrrl_rd");

        // reset mid-operation
        wr(8'd2, 8'h18);
        wr(8'd0, 8'h33);
        rx_frame(1'b0, 1'b0, 9'h011);
        rx_frame(1'b0, 1'b0, 9'h022);
        rx_frame(1'b0, 1'b0, 9'h033);
        peek(8'd5, 8'h13, "pre_rst_fstat");
        #1;
        i_rst_n = 1'b0;
        peek(8'd1, 8'h20, "arst_ucsra");
        peek(8'd5, 8'h00, "arst_fstat");
        chk("arst_txvalid", 16'(o_tx_valid), 16'h0);
        chk("arst_ubrr", 16'(o_ubrr), 16'h000);
        tick(); tick();
        i_rst_n = 1'b1;
        tick();
        peek(8'd1, 8'h20, "post_rst_ucsra");
        peek(8'd0, 8'h00, "post_rst_udr");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/usart_regs_fifo.md
USART_REGS_FIFO -- requirements
Module: usart_regs_fifo

Interface
REQ-001 Parameter BASE_ADDR, default 8'h00: address of UDR; all other registers sit at fixed offsets from it.
REQ-002 Parameter TX_DEPTH, default 4: TX FIFO entries; a power of two, at least 2.
REQ-003 Parameter RX_DEPTH, default 4: RX FIFO entries; a power of two, at least 2.
REQ-004 Parameter UBRR_W, default 12: baud divisor width, range 9..16.
REQ-005 The block SHALL use one clock, i_fosk, and an asynchronous active-low reset, i_rst_n.
REQ-006 Ports SHALL be, in this order:
- i_fosk  in  1  clock.
- i_rst_n  in  1  async reset, active low.
- i_addr  in  8  register address.
- i_word  in  8  write data.
- i_we  in  1  write strobe.
- i_re  in  1  read strobe; pops the RX FIFO.
- o_word  out  8  read data, combinational from i_addr.
- o_tx_data  out  9  TX FIFO head, {tx8, data}.
- o_tx_valid  out  1  TX head is valid.
- i_tx_ready  in  1  transmitter takes the head.
- i_txc  in  1  transmit shift complete, level.
- i_rx_data  in  9  received {rx8, data}.
- i_rx_fe  in  1  frame error of the received frame.
- i_rx_pe  in  1  parity error of the received frame.
- i_rx_valid  in  1  one-cycle frame-received strobe.
- o_ubrr  out  UBRR_W  baud divisor.
- o_ubrr_we  out  1  divisor-updated pulse.
- o_u2x, o_mpcm, o_txen, o_rxen, o_usbs, o_umsel, o_ucpol  out  1 each  control bits.
- o_ucsz  out  3  {ucsz2, ucsz1:0}.
- o_upm  out  2  parity mode.
- o_irq  out  1  interrupt request.

Function
REQ-007 The register map SHALL be, as offsets from BASE_ADDR: +0 UDR, +1 UCSRA, +2 UCSRB, +3 UCSRC/UBRRH, +4 UBRRL, +5 FSTAT; any other address SHALL read 8'h00 and ignore writes.
REQ-008 A write to UDR SHALL push {UCSRB.tx8, i_word} into the TX FIFO only when txen=1 and the FIFO is not full, judged on the pre-cycle level even if a pop occurs in the same cycle; otherwise the write SHALL be dropped.
REQ-009 o_tx_valid SHALL equal (TX FIFO not empty) AND txen; a pop SHALL occur when o_tx_valid and i_tx_ready are both high.
REQ-010 A read of UDR with i_re=1 SHALL return the RX head data[7:0] and pop the entry; a read of an empty RX FIFO SHALL return 8'h00 and pop nothing.
REQ-011 Each RX entry SHALL store 11 bits {fe, pe, rx8, data}; UCSRA.FE, UCSRA.PE and UCSRB.RXB8 SHALL reflect the head entry.
REQ-012 When i_rx_valid=1 and rxen=1, the frame SHALL be pushed into the RX FIFO if it is not full, or if it is full and a UDR pop occurs in the same cycle; otherwise the frame SHALL be dropped and DOR set.
REQ-013 DOR SHALL clear on any UDR pop.
REQ-014 UCSRA read SHALL be {RXC = RX FIFO not empty, TXC, UDRE = TX FIFO not full, FE, DOR, PE, U2X, MPCM}.
REQ-015 Writing UCSRA SHALL update U2X and MPCM; TXC is write-1-to-clear.
REQ-016 TXC SHALL set on a rising edge of i_txc while the TX FIFO is empty; if set and clear occur in the same cycle, set SHALL win.
REQ-017 UCSRB SHALL be {RXCIE, TXCIE, UDRIE, RXEN, TXEN, UCSZ2, RXB8 (read-only), TX8}.
REQ-018 Clearing TXEN SHALL flush the TX FIFO.
REQ-019 Clearing RXEN SHALL flush the RX FIFO and clear DOR.
REQ-020 A write at +3 with i_word[7]=1 SHALL load UCSRC {URSEL, UMSEL, UPM[1:0], USBS, UCSZ[1:0], UCPOL}.
REQ-021 A write at +3 with i_word[7]=0 SHALL load UBRRH = i_word[UBRR_W-9:0].
REQ-022 For +3 reads, a toggle flag SHALL flip on each i_re at +3 and clear on any access at another address.
REQ-023 A +3 read SHALL return UBRRH (zero-extended) when the toggle flag is 0 and UCSRC when it is 1.
REQ-024 A write to UBRRH or UBRRL SHALL update o_ubrr at the next edge, and o_ubrr_we SHALL pulse for exactly that one cycle, aligned with the new value.
REQ-025 FSTAT SHALL read {tx_level[3:0], rx_level[3:0]}, saturating at 15.
REQ-026 o_irq SHALL equal (RXCIE & RXC) | (TXCIE & TXC) | (UDRIE & UDRE), combinational from registered state.
REQ-027 Writes and pops SHALL take effect at the same edge; status SHALL be visible on o_word in the following cycle.

Reset
REQ-028 On i_rst_n low, all registers and both FIFOs SHALL clear, the toggle flag SHALL be 0, o_tx_valid and o_ubrr_we SHALL be 0, and every control output SHALL be 0.
REQ-029 UDRE SHALL read 1 out of reset.
REQ-030 Reset asserted mid-operation SHALL discard FIFO contents without issuing a partial pop.

Structure
REQ-031 Package usart_pkg SHALL hold the register offsets, UCSRA/UCSRB/UCSRC bit indices, and the RX entry field layout.
REQ-032 A single sub-module, usart_fifo (parameters WIDTH and DEPTH; push, pop, full, empty, level), SHALL be instantiated once for TX and once for RX.

Verification
REQ-033 TXEN=1; 5 UDR writes of 0x11..0x15 with i_tx_ready=0 and TX_DEPTH=4 -> 4 entries stored, 0x15 dropped, UDRE=0, FSTAT=0x40.
REQ-034 RX FIFO full; i_rx_valid with a simultaneous UDR read -> frame accepted, DOR=0; repeat without the read -> DOR=1; next UDR read -> DOR=0.
REQ-035 i_txc rises with the TX FIFO empty -> TXC=1 and o_irq=1 (TXCIE=1); write UCSRA 0x40 in the same cycle as a new i_txc edge -> TXC stays 1.
REQ-036 Write +3 0x05, then +4 0xA0 -> o_ubrr=0x5A0, with o_ubrr_we pulsing once per write; two consecutive +3 reads -> 0x05, then the UCSRC value.
REQ-037 Assert reset with 3 RX entries pending -> RXC=0, FSTAT=0x00, UDRE=1, o_tx_valid=0.
